td4_core_param: RTL and testbench
=================================

Name: td4_core_param

Overview:
- Parametrised successor to the team's 4-bit TD4 CPU core.
- Widths are generic: DATA_W for registers/ALU/ports, ADDR_W for the program counter.
- Program memory is external, read through a combinational fetch port.
- New over TD4: JC and HLT instructions, HALT state, run/single-step control, retire strobe and observable flags.
- With DATA_W=4, ADDR_W=4 the original TD4 opcodes execute bit-identically.

Parameters:
DATA_W, 4, width of A, B, OUT, IN, ALU and immediate field
ADDR_W, 4, width of PC/IADDR; must satisfy 1 <= ADDR_W <= DATA_W (elaboration error otherwise)

Ports:
CLK  input  1  clock, rising-edge
CLR  input  1  reset, asynchronous, active-high
RUN  input  1  1 = execute one instruction every cycle; 0 = single-step mode
STEP  input  1  step request, synchronous to CLK; a 0->1 transition (vs. previous cycle) executes one instruction when RUN=0
IN  input  DATA_W  input port
IDATA  input  DATA_W+4  instruction at IADDR, valid same cycle; [DATA_W+3:DATA_W]=opcode, [DATA_W-1:0]=Im
IADDR  output  ADDR_W  program counter
OUT  output  DATA_W  output port register
CARRY  output  1  carry flag
HALTED  output  1  core is in HALT state
RETIRE  output  1  registered 1-cycle pulse: an instruction executed on the previous edge

Behaviour:
Reset (CLR=1, async):
- A, B, OUT, PC, CARRY, RETIRE and the STEP history flop all go to 0.
- FSM goes to ACTIVE; HALTED=0.
- Reset overrides everything, including mid-step and HALT.

Execute enable:
- exe = ACTIVE && (RUN || (STEP && !step_q)); step_q is STEP registered every cycle.
- When exe=0, all architectural state holds.
- A step edge while RUN=1 is simply absorbed.

Datapath (evaluated when exe=1; all updates on the same rising edge; single-cycle, no pipeline):
- src selected by opcode[1:0] (the low two bits of the opcode field): 00=A, 01=B, 10=IN, 11=zero.
- sum = src + Im, computed DATA_W+1 wide; result = sum[DATA_W-1:0]; cy = sum[DATA_W].
- CARRY <= cy on every executed instruction, including MOV/IN/OUT/jumps/HLT/NOP.
- Non-executed cycles do not touch CARRY.

Opcodes (destination written with result):
- 0000 ADD A,Im -> A
- 0001 MOV A,B -> A
- 0010 IN A -> A (Im added, per TD4)
- 0011 MOV A,Im -> A
- 0100 MOV B,A -> B
- 0101 ADD B,Im -> B
- 0110 IN B -> B
- 0111 MOV B,Im -> B
- 1001 OUT B -> OUT
- 1011 OUT Im -> OUT
- 1111 JMP Im: PC <= result[ADDR_W-1:0]
- 1110 JNC Im: jump if CARRY==0 (flag value before this edge)
- 1100 JC Im: jump if CARRY==1
- 1010 HLT: FSM -> HALT; PC holds at the HLT address
- 1000, 1101 NOP

PC update:
- Non-jump, not-taken jump, or NOP: PC <= PC+1, wrapping from 2^ADDR_W-1 to 0.
- Jump targets use the low ADDR_W bits of Im; upper Im bits are ignored.

FSM:
- ACTIVE -> HALT on an executed HLT.
- HALT is left only by CLR. HALTED=1 in HALT; STEP and RUN are ignored there.

RETIRE:
- RETIRE <= exe, so it is 1 for exactly one cycle after each executed instruction, including HLT.
- RETIRE is 0 in HALT.

Overflow: ADD wraps modulo 2^DATA_W and sets CARRY.

Test Plan:
1. DATA_W=4, ADDR_W=4, RUN=1. Program: MOV A,3; ADD A,14; JNC 0; OUT Im 5; HLT.
   -> A=1, CARRY=1 after addr 1; JNC not taken; OUT=5; HALTED=1; IADDR stays 4 for 10+ cycles; RETIRE stops.
2. TD4 LED loop: OUT Im 1; OUT Im 2; JMP 0.
   -> OUT sequence 1, 2, 1, 2…; IADDR 0, 1, 2, 0.
   Also: 16 NOPs from 0 -> IADDR wraps 15->0.
3. RUN=0 with STEP held high for 5 cycles -> exactly one instruction retires (one RETIRE pulse).
   Three separate 0->1 edges -> IADDR advances by 3.
   STEP edges while HALTED -> no change.
4. DATA_W=8, ADDR_W=4. Program: MOV B,200; ADD B,100; JC 9.
   -> B=44, CARRY=1, IADDR=9.
   JMP 0xF3 -> IADDR=3.
5. IN A with IN=9, Im=0 -> A=9, CARRY=0.
   Assert CLR asynchronously mid-cycle while running/halted -> all outputs 0 immediately, HALTED=0; execution resumes from 0 after release.

Source files
------------

// File: rtl/td4_core_param.sv
// td4_core_param: parametrised TD4 core with JC/HLT, run/single-step control, retire strobe and flags.
module td4_core_param #(
    parameter int DATA_W = 4,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              run,
    input  logic              step,
    input  logic [DATA_W-1:0] in,
    input  logic [DATA_W+3:0] idata,
    output logic [ADDR_W-1:0] iaddr,
    output logic [DATA_W-1:0] out,
    output logic              carry,
    output logic              halted,
    output logic              retire
);
    if (ADDR_W < 1 || ADDR_W > DATA_W) begin : g_bad_width
        $error("td4_core_param: ADDR_W must satisfy 1 <= ADDR_W <= DATA_W");
    end

    typedef enum logic {ACTIVE, HALT} state_t;

    state_t            state, state_n;
    logic [DATA_W-1:0] a, b, src, im, res;
    logic [ADDR_W-1:0] pc_n;
    logic [3:0]        op;
    logic              cy, step_q, exe, jump, hlt, wr_a, wr_b, wr_o;

    always_comb begin
        op      = idata[DATA_W+3:DATA_W];
        im      = idata[DATA_W-1:0];
        src     = op[1:0] == 2'b00 ? a : op[1:0] == 2'b01 ? b : op[1:0] == 2'b10 ? in : '0;
        {cy, res} = {1'b0, src} + {1'b0, im};
        exe     = state == ACTIVE && (run || (step && !step_q));
        hlt     = op == 4'b1010;
        // conditional jumps test the flag as it stood before this edge
        jump    = op == 4'b1111 || (op == 4'b1110 && !carry) || (op == 4'b1100 && carry);
        pc_n    = hlt ? iaddr : jump ? im[ADDR_W-1:0] : iaddr + ADDR_W'(1);
        wr_a    = op[3:2] == 2'b00;
        wr_b    = op[3:2] == 2'b01;
        wr_o    = op == 4'b1001 || op == 4'b1011;
        state_n = exe && hlt ? HALT : state;
        halted  = state == HALT;
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            a      <= '0;
            b      <= '0;
            out    <= '0;
            iaddr  <= '0;
            carry  <= 1'b0;
            retire <= 1'b0;
            step_q <= 1'b0;
            state  <= ACTIVE;
        end else begin
            step_q <= step;
            retire <= exe;
            state  <= state_n;
            if (exe) begin
                carry <= cy;
                iaddr <= pc_n;
                a     <= wr_a ? res : a;
                b     <= wr_b ? res : b;
                out   <= wr_o ? res : out;
            end
        end
    end
endmodule

// File: tb/tb_td4_core_param.sv
// tb_td4_core_param: vector tables, hand sequences and a randomized reference model for td4_core_param.
module tb_td4_core_param;
    logic        clk = 1'b0;
    logic        clr4 = 1'b1, run4 = 1'b0, step4 = 1'b0;
    logic        clr8 = 1'b1, run8 = 1'b0, step8 = 1'b0;
    logic [3:0]  in4 = '0;
    logic [7:0]  in8 = '0;
    logic [7:0]  rom4 [16];
    logic [11:0] rom8 [16];
    logic [7:0]  idata4;
    logic [11:0] idata8;
    logic [3:0]  iaddr4, out4, iaddr8;
    logic [7:0]  out8;
    logic        carry4, halted4, retire4, carry8, halted8, retire8;
    int          n_tests = 0, n_fail = 0;

    always #5 clk = ~clk;

    assign idata4 = rom4[iaddr4];
    assign idata8 = rom8[iaddr8];

    td4_core_param #(.DATA_W(4), .ADDR_W(4)) u4 (
        .clk(clk), .clr(clr4), .run(run4), .step(step4), .in(in4), .idata(idata4),
        .iaddr(iaddr4), .out(out4), .carry(carry4), .halted(halted4), .retire(retire4)
    );

    td4_core_param #(.DATA_W(8), .ADDR_W(4)) u8 (
        .clk(clk), .clr(clr8), .run(run8), .step(step8), .in(in8), .idata(idata8),
        .iaddr(iaddr8), .out(out8), .carry(carry8), .halted(halted8), .retire(retire8)
    );

    typedef struct {
        int run, step, inv;
        int iaddr, out, carry, halted, retire;
    } vec_t;

    vec_t tv[$];

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk4(string nm, int iaddr, int out, int carry, int halted, int retire);
        chk({nm, ".iaddr"}, 32'(iaddr4), 32'(iaddr));
        chk({nm, ".out"}, 32'(out4), 32'(out));
        chk({nm, ".carry"}, 32'(carry4), 32'(carry));
        chk({nm, ".halted"}, 32'(halted4), 32'(halted));
        chk({nm, ".retire"}, 32'(retire4), 32'(retire));
    endtask

    task automatic add_vec(int run, int iaddr, int out, int carry, int halted, int retire);
        vec_t v;
        v = '{run, 0, 0, iaddr, out, carry, halted, retire};
        tv.push_back(v);
    endtask

    task automatic run_table(string tag);
        foreach (tv[i]) begin
            run4  = tv[i].run[0];
            step4 = tv[i].step[0];
            in4   = 4'(tv[i].inv);
            @(negedge clk);
            chk4($sformatf("%s[%0d]", tag, i), tv[i].iaddr, tv[i].out, tv[i].carry, tv[i].halted, tv[i].retire);
        end
        tv.delete();
    endtask

    task automatic reset4();
        clr4 = 1'b1;
        @(negedge clk);
        clr4 = 1'b0;
    endtask

    // behavioural reference for the 8-bit core, one call per rising edge
    int ma, mb, mo, mpc, mc, mh, msq, mret;

    task automatic model_reset();
        ma = 0; mb = 0; mo = 0; mpc = 0; mc = 0; mh = 0; msq = 0; mret = 0;
    endtask

    task automatic model_edge(int run, int step, int inv);
        int ins, op, im, src, sum, exe;
        exe = (mh == 0) && (run != 0 || (step != 0 && msq == 0)) ? 1 : 0;
        msq  = step;
        mret = exe;
        if (exe == 0) return;
        ins = int'(rom8[mpc]);
        op  = ins / 256;
        im  = ins % 256;
        src = (op % 4 == 0) ? ma : (op % 4 == 1) ? mb : (op % 4 == 2) ? inv : 0;
        sum = src + im;
        if (op < 4) ma = sum % 256;
        else if (op < 8) mb = sum % 256;
        else if (op == 9 || op == 11) mo = sum % 256;
        if (op == 10) mh = 1;
        else if (op == 15 || (op == 14 && mc == 0) || (op == 12 && mc == 1)) mpc = im % 16;
        else mpc = (mpc + 1) % 16;
        mc = sum > 255 ? 1 : 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cnt;
        foreach (rom4[i]) rom4[i] = 8'h80;
        foreach (rom8[i]) rom8[i] = 12'h800;
        @(negedge clk);
        chk4("reset4", 0, 0, 0, 0, 0);
        chk("reset8.iaddr", 32'(iaddr8), 0);
        chk("reset8.out", 32'(out8), 0);
        chk("reset8.flags", 32'({carry8, halted8, retire8}), 0);

        // carry from ADD, JNC not taken, OUT Im, HLT
        rom4[0] = 8'h33; rom4[1] = 8'h0E; rom4[2] = 8'hE0; rom4[3] = 8'hB5; rom4[4] = 8'hA0;
        in4 = 4'd0;
        reset4();
        add_vec(1, 1, 0, 0, 0, 1);
        add_vec(1, 2, 0, 1, 0, 1);
        add_vec(1, 3, 0, 0, 0, 1);
        add_vec(1, 4, 5, 0, 0, 1);
        add_vec(1, 4, 5, 0, 1, 1);
        for (int i = 0; i < 11; i++) add_vec(1, 4, 5, 0, 1, 0);
        run_table("prog1");

        // LED loop
        foreach (rom4[i]) rom4[i] = 8'h80;
        rom4[0] = 8'hB1; rom4[1] = 8'hB2; rom4[2] = 8'hF0;
        run4 = 1'b0;
        reset4();
        for (int i = 0; i < 2; i++) begin
            add_vec(1, 1, 1, 0, 0, 1);
            add_vec(1, 2, 2, 0, 0, 1);
            add_vec(1, 0, 2, 0, 0, 1);
        end
        run_table("led");

        // PC wrap through NOPs
        foreach (rom4[i]) rom4[i] = 8'h80;
        run4 = 1'b0;
        reset4();
        run4 = 1'b1;
        for (int i = 1; i <= 17; i++) begin
            @(negedge clk);
            if (i == 15 || i == 16 || i == 17) chk($sformatf("wrap%0d", i), 32'(iaddr4), 32'(i % 16));
        end

        // single-step control
        run4 = 1'b0;
        rom4[4] = 8'hA0;
        reset4();
        step4 = 1'b1;
        cnt = 0;
        repeat (5) begin @(negedge clk); cnt += int'(retire4); end
        step4 = 1'b0;
        @(negedge clk);
        cnt += int'(retire4);
        chk("step_hold_retires", 32'(cnt), 1);
        chk("step_hold_iaddr", 32'(iaddr4), 1);
        repeat (3) begin step4 = 1'b1; @(negedge clk); step4 = 1'b0; @(negedge clk); end
        chk("three_steps_iaddr", 32'(iaddr4), 4);
        step4 = 1'b1;
        @(negedge clk);
        chk4("step_hlt", 4, 0, 0, 1, 1);
        step4 = 1'b0;
        @(negedge clk);
        cnt = 0;
        repeat (4) begin
            step4 = 1'b1; @(negedge clk); cnt += int'(retire4);
            step4 = 1'b0; @(negedge clk); cnt += int'(retire4);
        end
        run4 = 1'b1;
        repeat (3) begin @(negedge clk); cnt += int'(retire4); end
        chk("halted_steps_retires", 32'(cnt), 0);
        chk4("halted_steps", 4, 0, 0, 1, 0);

        // IN A, observed through OUT B, then async reset while halted
        foreach (rom4[i]) rom4[i] = 8'h80;
        rom4[0] = 8'h20; rom4[1] = 8'h40; rom4[2] = 8'h90; rom4[3] = 8'hA0;
        run4 = 1'b0;
        reset4();
        in4 = 4'd9;
        run4 = 1'b1;
        @(negedge clk);
        chk("in_a_carry", 32'(carry4), 0);
        repeat (2) @(negedge clk);
        chk("in_a_out", 32'(out4), 9);
        @(negedge clk);
        chk("in_prog_halted", 32'(halted4), 1);
        #2 clr4 = 1'b1;
        #1 chk4("async_clr_halted", 0, 0, 0, 0, 0);
        @(negedge clk);
        clr4 = 1'b0;
        @(negedge clk);
        chk4("resume_after_clr", 1, 0, 0, 0, 1);

        // async reset mid-run with carry set
        rom4[0] = 8'h33; rom4[1] = 8'h0E; rom4[2] = 8'hE0; rom4[3] = 8'hB5; rom4[4] = 8'hA0;
        in4 = 4'd0;
        reset4();
        repeat (2) @(negedge clk);
        chk("pre_clr_carry", 32'(carry4), 1);
        #2 clr4 = 1'b1;
        #1 chk4("async_clr_running", 0, 0, 0, 0, 0);
        @(negedge clk);
        clr4 = 1'b0;
        @(negedge clk);
        chk4("resume_running", 1, 0, 0, 0, 1);

        // 8-bit datapath: overflow, JC, JMP with upper Im bits
        rom8[0] = 12'h7C8; rom8[1] = 12'h564; rom8[2] = 12'hC09;
        rom8[9] = 12'hFF3; rom8[3] = 12'h900; rom8[4] = 12'hA00;
        clr8 = 1'b1;
        @(negedge clk);
        clr8 = 1'b0;
        run8 = 1'b1;
        @(negedge clk);
        chk("w8_movb_iaddr", 32'(iaddr8), 1);
        @(negedge clk);
        chk("w8_addb_carry", 32'(carry8), 1);
        @(negedge clk);
        chk("w8_jc_iaddr", 32'(iaddr8), 9);
        @(negedge clk);
        chk("w8_jmp_iaddr", 32'(iaddr8), 3);
        @(negedge clk);
        chk("w8_outb", 32'(out8), 44);
        @(negedge clk);
        chk("w8_halted", 32'(halted8), 1);

        // randomized programs against the reference model
        for (int r = 0; r < 24; r++) begin
            foreach (rom8[i]) rom8[i] = 12'($urandom);
            clr8 = 1'b1;
            run8 = 1'b0;
            step8 = 1'b0;
            @(negedge clk);
            clr8 = 1'b0;
            model_reset();
            for (int c = 0; c < 40; c++) begin
                run8  = (r % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 4) == 0);
                step8 = 1'($urandom_range(0, 1));
                in8   = 8'($urandom);
                model_edge(int'(run8), int'(step8), int'(in8));
                @(negedge clk);
                chk($sformatf("rnd%0d_%0d.iaddr", r, c), 32'(iaddr8), 32'(mpc));
                chk($sformatf("rnd%0d_%0d.out", r, c), 32'(out8), 32'(mo));
                chk($sformatf("rnd%0d_%0d.carry", r, c), 32'(carry8), 32'(mc));
                chk($sformatf("rnd%0d_%0d.halted", r, c), 32'(halted8), 32'(mh));
                chk($sformatf("rnd%0d_%0d.retire", r, c), 32'(retire8), 32'(mret));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
